ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  PS/2 keyboard line receiver. Filters the raw ps2_clk/ps2_data pins and deserialises the 11-bit frames.
//  Folds the E0/F0/E1 prefix bytes into the 11-bit ps2_key word that system consumes:
//  [7:0] scancode, [8] extended, [9] pressed, [10] toggles on every event.
//  Sits between the keyboard pins and system.ps2_key, for builds without the HPS key path.
// PARAMETERS
//  FILTER_LEN      8      consecutive equal samples before the filtered ps2_clk changes level
//  TIMEOUT_CYCLES  48000  clk_24 cycles allowed between falling edges mid-frame (2 ms at 24 MHz)
// PORTS
//  clk_24       in   1   system clock, 24 MHz
//  reset_n      in   1   asynchronous active-low reset
//  ps2_clk_in   in   1   raw PS/2 clock pin, asynchronous to clk_24
//  ps2_data_in  in   1   raw PS/2 data pin, asynchronous to clk_24
//  ps2_key      out  11  {toggle, pressed, extended, scancode[7:0]}
//  frame_err    out  1   one-cycle pulse when a frame is discarded (start, parity, stop or timeout)
//  busy         out  1   high while a frame is being received
// BEHAVIOUR
//  - Reset (async, reset_n=0): ps2_key=0, frame_err=0, busy=0, filtered clk=1, state IDLE.
//    Reset also clears the prefix flags, the skip counter and the timeout counter.
//    Reset mid-frame abandons the partial frame silently; no frame_err.
//  - Input conditioning: both pins pass through 2-flop synchronisers.
//    The filtered clk takes the synchronised value only after FILTER_LEN consecutive identical samples.
//    Data is sampled, already synchronised, on the cycle a filtered-clk 1->0 transition is detected.
//  - Frame: start(0), d0..d7 LSB first, odd parity, stop(1). The 4-bit bit counter runs 0..10.
//  - FSM states:
//    IDLE: on a falling edge with data=0, go to RECV with bitcnt=1 and busy=1.
//          On a falling edge with data=1, frame_err pulses and the FSM stays in IDLE.
//    RECV: shift in d0..d7 on bitcnt 1..8, check parity on 9, check stop on 10, then return to IDLE.
//    - Parity fail (d0..d7 plus parity not odd) or stop=0: byte discarded, frame_err pulses, prefix flags cleared.
//    - Timeout counter clears on every falling edge.
//      If it reaches TIMEOUT_CYCLES in RECV: go to IDLE, frame_err pulses, prefix flags cleared.
//      A falling edge in the same cycle as expiry wins; the edge is consumed and no timeout occurs.
//  - Byte handling, one cycle after a valid stop bit (pipeline latency 1):
//    - skip counter != 0: the counter decrements and the byte is dropped.
//    - E0: set ext. F0: set rel. Neither emits an event.
//    - E1: load skip counter=7, then emit on the cycle after the 7th skipped byte:
//      ps2_key <= {~ps2_key[10], 1'b1, 1'b1, 8'h77}.
//    - With no prefix pending, bytes 00, AA, EE, FA, FC, FE, FF are discarded (BAT/ack/echo/resend/error).
//    - Any other byte: ps2_key <= {~ps2_key[10], ~rel, ext, byte}, then ext=rel=0.
//  - ps2_key holds its value between events. The toggle bit is the only change indicator, which matches how system consumes it.
//  - frame_err and the event update never coincide. busy falls in the same cycle the event registers.
// TESTING
//  1. Frame 0x1C (parity 0) after reset -> ps2_key=0x61C one cycle after the stop edge, frame_err stays 0.
//  2. Then frames F0,1C -> ps2_key=0x01C. Then frames E0,F0,75 -> ps2_key=0x575.
//  3. Frame 0x1C with the parity bit flipped -> frame_err is a 1-cycle pulse and ps2_key is unchanged.
//     A following F0 is then not affected by stale flags.
//  4. 5 bits sent, then clk held high for 48000 cycles -> frame_err pulses and busy=0.
//     A following 0x29 frame -> ps2_key toggle flips, value 0x?29, pressed=1.
//  5. 3-cycle low glitch on ps2_clk_in in IDLE and mid-frame -> no bit is consumed.
//     A valid 0x1C then decodes correctly.
//  6. FA with no prefix -> no change. Sequence E1 14 77 E1 F0 14 F0 77 -> exactly one event, {t,1,1,0x77}.
//     Assert reset_n mid-frame -> all outputs 0 and no frame_err.

Source files
------------

// File: rtl/ps2_key_decoder_if.sv
// Pin and key-word bundle between the PS/2 connector side and the key decoder.
// The decoder takes the slave view; whatever drives the pins takes the master view.
interface ps2_key_decoder_if;
   logic        ps2_clk_in;
   logic        ps2_data_in;
   logic [10:0] ps2_key;
   logic        frame_err;
   logic        busy;

   modport master (
      output ps2_clk_in,
      output ps2_data_in,
      input  ps2_key,
      input  frame_err,
      input  busy
   );

   modport slave (
      input  ps2_clk_in,
      input  ps2_data_in,
      output ps2_key,
      output frame_err,
      output busy
   );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises and filters the pins, deserialises 11-bit frames and
// folds E0/F0/E1 prefixes into the {toggle, pressed, extended, scancode} key word.
module ps2_key_decoder #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 48000
) (
   input  logic             clk_24,
   input  logic             reset_n,
   ps2_key_decoder_if.slave bus
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {IDLE, RECV} state_t;

   logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
   logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
   logic          filt_clk_q, filt_clk_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   state_t        state_q, state_d;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          byte_rdy_q, byte_rdy_d;
   logic          ext_q, ext_d, rel_q, rel_d;
   logic [2:0]    skip_q, skip_d;
   logic [10:0]   key_q, key_d;
   logic          err_q, err_d;
   logic          busy_q, busy_d;
   logic          fall, frame_fail;

   // Power-on/keyboard status bytes that carry no key information.
   function automatic logic is_status_byte(input logic [7:0] b);
      return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
   endfunction

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
      clk_s1_d   = bus.ps2_clk_in;
      clk_s2_d   = clk_s1_q;
      dat_s1_d   = bus.ps2_data_in;
      dat_s2_d   = dat_s1_q;
      filt_clk_d = filt_clk_q;
      filt_cnt_d = filt_cnt_q;
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      shift_d    = shift_q;
      tmo_d      = tmo_q;
      byte_rdy_d = 1'b0;
      ext_d      = ext_q;
      rel_d      = rel_q;
      skip_d     = skip_q;
      key_d      = key_q;
      err_d      = 1'b0;
      busy_d     = busy_q;
      fall       = 1'b0;
      frame_fail = 1'b0;

      // The filtered clock follows the pin only after FILTER_LEN agreeing samples.
      if (clk_s2_q == filt_clk_q) begin
         filt_cnt_d = '0;
      end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
         filt_clk_d = clk_s2_q;
         filt_cnt_d = '0;
         fall       = filt_clk_q;
      end else begin
         filt_cnt_d = filt_cnt_q + 1'b1;
      end

      if (fall) tmo_d = '0;

      case (state_q)
         IDLE: begin
            if (fall) begin
               if (!dat_s2_q) begin
                  state_d  = RECV;
                  bitcnt_d = 4'd1;
                  busy_d   = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RECV: begin
            if (fall) begin
               if (bitcnt_q <= 4'd8) begin
                  shift_d  = {dat_s2_q, shift_q[7:1]};
                  bitcnt_d = bitcnt_q + 4'd1;
               end else if (bitcnt_q == 4'd9) begin
                  if (^{shift_q, dat_s2_q}) bitcnt_d = 4'd10;
                  else                      frame_fail = 1'b1;
               end else begin
                  state_d  = IDLE;
                  bitcnt_d = 4'd0;
                  if (dat_s2_q) byte_rdy_d = 1'b1;
                  else          frame_fail = 1'b1;
               end
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
               frame_fail = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // busy stays up through the byte-handling cycle so it drops together with the event.
      if (byte_rdy_q) begin
         busy_d = 1'b0;
         if (skip_q != 3'd0) begin
            skip_d = skip_q - 3'd1;
            if (skip_q == 3'd1) key_d = {~key_q[10], 1'b1, 1'b1, 8'h77};
         end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (shift_q == 8'hF0) begin
            rel_d = 1'b1;
         end else if (shift_q == 8'hE1) begin
            skip_d = 3'd7;
         end else if (!(ext_q || rel_q) && is_status_byte(shift_q)) begin
            key_d = key_q;
         end else begin
            key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
            ext_d = 1'b0;
            rel_d = 1'b0;
         end
      end

      if (frame_fail) begin
         state_d  = IDLE;
         bitcnt_d = 4'd0;
         tmo_d    = '0;
         busy_d   = 1'b0;
         err_d    = 1'b1;
         ext_d    = 1'b0;
         rel_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_24 or negedge reset_n) begin
      if (!reset_n) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         filt_clk_q <= 1'b1;
         filt_cnt_q <= '0;
         state_q    <= IDLE;
         bitcnt_q   <= 4'd0;
         shift_q    <= 8'h00;
         tmo_q      <= '0;
         byte_rdy_q <= 1'b0;
         ext_q      <= 1'b0;
         rel_q      <= 1'b0;
         skip_q     <= 3'd0;
         key_q      <= 11'h000;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         clk_s1_q   <= clk_s1_d;
         clk_s2_q   <= clk_s2_d;
         dat_s1_q   <= dat_s1_d;
         dat_s2_q   <= dat_s2_d;
         filt_clk_q <= filt_clk_d;
         filt_cnt_q <= filt_cnt_d;
         state_q    <= state_d;
         bitcnt_q   <= bitcnt_d;
         shift_q    <= shift_d;
         tmo_q      <= tmo_d;
         byte_rdy_q <= byte_rdy_d;
         ext_q      <= ext_d;
         rel_q      <= rel_d;
         skip_q     <= skip_d;
         key_q      <= key_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.ps2_key   = key_q;
   assign bus.frame_err = err_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomised bench for ps2_key_decoder: a frame-level key model fills a scoreboard queue and a
// monitor pops one entry per key-word change or frame_err pulse.
module tb_ps2_key_decoder;

   localparam int TIMEOUT_CYCLES = 48000;

   logic clk_24  = 1'b0;
   logic reset_n = 1'b0;

   ps2_key_decoder_if bus ();

   ps2_key_decoder #(
      .FILTER_LEN    (8),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk_24 (clk_24),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk_24 = ~clk_24;

   typedef enum {EXP_EVENT, EXP_ERR} kind_t;
   typedef struct {
      kind_t       kind;
      logic [10:0] key;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Keyboard-level model state: pending prefixes, bytes left to skip, last key word.
   bit          m_ext, m_rel;
   int          m_skip;
   logic [10:0] m_key;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic void model_reset();
      m_ext  = 1'b0;
      m_rel  = 1'b0;
      m_skip = 0;
      m_key  = 11'h000;
   endfunction

   function automatic void push_err(input bit clear_prefix);
      exp_q.push_back('{kind: EXP_ERR, key: 11'h000});
      if (clear_prefix) begin
         m_ext = 1'b0;
         m_rel = 1'b0;
      end
   endfunction

   function automatic void emit(input logic [9:0] v);
      m_key = {~m_key[10], v};
      exp_q.push_back('{kind: EXP_EVENT, key: m_key});
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      if (m_skip > 0) begin
         m_skip--;
         if (m_skip == 0) emit({1'b1, 1'b1, 8'h77});
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_rel = 1'b1;
      end else if (b == 8'hE1) begin
         m_skip = 7;
      end else if (!m_ext && !m_rel && (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF})) begin
         m_skip = 0;
      end else begin
         emit({~m_rel, m_ext, b});
         m_ext = 1'b0;
         m_rel = 1'b0;
      end
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk_24);
   endtask

   // One PS/2 bit: data set while the clock is high, then a low phase; optional 3-cycle glitch.
   task automatic ps2_bit(input bit b, input int hp, input bit glitch);
      bus.ps2_data_in = b;
      if (glitch) begin
         wait_clk(4);
         bus.ps2_clk_in = 1'b0;
         wait_clk(3);
         bus.ps2_clk_in = 1'b1;
         wait_clk(hp - 7);
      end else begin
         wait_clk(hp);
      end
      bus.ps2_clk_in = 1'b0;
      wait_clk(hp);
      bus.ps2_clk_in = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int hp, input int glitch_bit);
      logic [10:0] bits;
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         if (i == 9 && bad_par) push_err(1'b1);
         if (i == 10) begin
            if (bad_par)       push_err(1'b0);  // stop bit then arrives as a stray edge in IDLE
            else if (bad_stop) push_err(1'b1);
            else               model_byte(b);
         end
         ps2_bit(bits[i], hp, i == glitch_bit);
      end
      bus.ps2_data_in = 1'b1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         wait_clk(1);
         n++;
      end
      wait_clk(20);
      check("scoreboard_drained", exp_q.size(), 0);
   endtask

   // Monitor: every frame_err pulse and every key-word change must match the queue head.
   logic [10:0] prev_key;
   bit          busy_prev, err_prev;

   always @(negedge clk_24) begin
      exp_t e;
      if (!reset_n) begin
         prev_key  = bus.ps2_key;
         busy_prev = 1'b0;
         err_prev  = 1'b0;
      end else begin
         if (bus.frame_err) begin
            check("frame_err_one_cycle", err_prev, 0);
            if (exp_q.size() == 0) begin
               check("unexpected_frame_err", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("frame_err_expected", e.kind == EXP_ERR, 1);
            end
         end
         if (bus.ps2_key !== prev_key) begin
            if (exp_q.size() == 0) begin
               check("unexpected_key_event", bus.ps2_key, prev_key);
            end else begin
               e = exp_q.pop_front();
               check("event_expected", e.kind == EXP_EVENT, 1);
               check("ps2_key", bus.ps2_key, e.key);
               check("busy_low_with_event", bus.busy, 0);
               check("busy_high_before_event", busy_prev, 1);
            end
         end
         prev_key  = bus.ps2_key;
         busy_prev = bus.busy;
         err_prev  = bus.frame_err;
      end
   end

   initial begin
      logic [7:0] status_bytes [7];
      logic [7:0] e1_seq [8];
      logic [7:0] b;
      int         r;
      status_bytes = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
      e1_seq       = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

      bus.ps2_clk_in  = 1'b1;
      bus.ps2_data_in = 1'b1;
      model_reset();
      wait_clk(5);
      check("reset_ps2_key", bus.ps2_key, 11'h000);
      check("reset_frame_err", bus.frame_err, 0);
      check("reset_busy", bus.busy, 0);
      reset_n = 1'b1;
      wait_clk(10);

      // Make and break codes with and without the extended prefix.
      send_frame(8'h1C, 0, 0, 16, -1);
      drain();
      check("make_1c", bus.ps2_key, 11'h61C);
      send_frame(8'hF0, 0, 0, 16, -1);
      send_frame(8'h1C, 0, 0, 16, -1);
      drain();
      check("break_1c", bus.ps2_key, 11'h01C);
      send_frame(8'hE0, 0, 0, 14, -1);
      send_frame(8'hF0, 0, 0, 14, -1);
      send_frame(8'h75, 0, 0, 14, -1);
      drain();
      check("ext_break_75", bus.ps2_key, 11'h575);

      // A parity error drops the byte and any pending prefix.
      send_frame(8'hE0, 0, 0, 16, -1);
      send_frame(8'h1C, 1, 0, 16, -1);
      drain();
      check("parity_err_key_held", bus.ps2_key, 11'h575);
      send_frame(8'h1C, 0, 0, 16, -1);
      drain();
      check("no_stale_prefix", bus.ps2_key, 11'h21C);

      // Timeout after a partial frame, then a clean frame.
      ps2_bit(1'b0, 16, 0);
      for (int i = 0; i < 4; i++) ps2_bit(((8'h29 >> i) & 8'h01) != 0, 16, 0);
      bus.ps2_data_in = 1'b1;
      wait_clk(20);
      check("busy_mid_frame", bus.busy, 1);
      push_err(1'b1);
      wait_clk(TIMEOUT_CYCLES + 50);
      check("busy_after_timeout", bus.busy, 0);
      check("timeout_err_seen", exp_q.size(), 0);
      send_frame(8'h29, 0, 0, 16, -1);
      drain();
      check("after_timeout_29", bus.ps2_key, 11'h629);

      // Clock glitches in IDLE and mid-frame are filtered out.
      bus.ps2_clk_in = 1'b0;
      wait_clk(3);
      bus.ps2_clk_in = 1'b1;
      wait_clk(40);
      send_frame(8'h1C, 0, 0, 16, 4);
      drain();
      check("glitch_filtered_1c", bus.ps2_key, 11'h21C);

      // Status byte is discarded; the Pause sequence yields a single event.
      send_frame(8'hFA, 0, 0, 14, -1);
      drain();
      check("status_fa_ignored", bus.ps2_key, 11'h21C);
      foreach (e1_seq[i]) send_frame(e1_seq[i], 0, 0, 13, -1);
      drain();
      check("pause_event", bus.ps2_key, 11'h777);

      // Randomised frames, prefixes, status bytes and occasional corrupted frames.
      for (int n = 0; n < 40; n++) begin
         r = int'($urandom_range(0, 15));
         if (r == 0)      b = 8'hE0;
         else if (r == 1) b = 8'hF0;
         else if (r == 2) b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h12;
         else if (r == 3) b = status_bytes[$urandom_range(0, 6)];
         else             b = 8'($urandom);
         r = int'($urandom_range(0, 9));
         send_frame(b, r == 0, r == 1, int'($urandom_range(12, 22)), -1);
      end
      drain();

      // Reset in the middle of a frame discards it silently.
      ps2_bit(1'b0, 16, 0);
      for (int i = 0; i < 3; i++) ps2_bit(1'b1, 16, 0);
      wait_clk(20);
      reset_n = 1'b0;
      wait_clk(2);
      check("midreset_ps2_key", bus.ps2_key, 11'h000);
      check("midreset_frame_err", bus.frame_err, 0);
      check("midreset_busy", bus.busy, 0);
      exp_q.delete();
      model_reset();
      bus.ps2_clk_in  = 1'b1;
      bus.ps2_data_in = 1'b1;
      wait_clk(3);
      reset_n = 1'b1;
      wait_clk(40);
      send_frame(8'h1C, 0, 0, 16, -1);
      drain();
      check("post_reset_1c", bus.ps2_key, 11'h61C);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
